// File: rtl/i2s_serial_tx_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : i2s_serial_tx_pkg
// Brief  : Shared audio constants and stereo sample type for the I2S paths.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package i2s_serial_tx_pkg;

  localparam int I2S_DATA_BITS  = 24;
  localparam int I2S_SLOT_BITS  = 32;
  localparam int I2S_FRAME_BITS = 2 * I2S_SLOT_BITS;

  typedef struct packed {
    logic signed [I2S_DATA_BITS-1:0] left;
    logic signed [I2S_DATA_BITS-1:0] right;
  } stereo_sample_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int i2s_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_bck_prescaler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : i2s_bck_prescaler
// Brief  : AMCLK-to-BCK divider with falling-edge event and 2x slow mode.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module i2s_bck_prescaler
  import i2s_serial_tx_pkg::*;
#(
  parameter int BCK_HALF = 2
) (
  input  logic AMCLK_i,
  input  logic reset_n,
  input  logic i_downsample_2x,
  output logic o_bck,
  output logic o_fall_evt
);

  localparam int c_cnt_w = i2s_cnt_width(2 * BCK_HALF);
  localparam logic [c_cnt_w-1:0] c_last_norm = c_cnt_w'(BCK_HALF - 1);
  localparam logic [c_cnt_w-1:0] c_last_slow = c_cnt_w'(2 * BCK_HALF - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_ds;
  logic               r_bck;
  logic               w_wrap;

  // The divide mode only changes at a wrap, so every BCK phase is whole.
  assign w_wrap = (r_cnt == (r_ds ? c_last_slow : c_last_norm));

  always_ff @(posedge AMCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_ds  <= 1'b0;
      r_bck <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_ds  <= i_downsample_2x;
      r_bck <= ~r_bck;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bck      = r_bck;
  assign o_fall_evt = w_wrap & r_bck;

endmodule
`default_nettype wire

// File: rtl/i2s_serial_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : i2s_serial_tx
// Brief  : Philips-I2S master transmitter with optional 2x rate reduction.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module i2s_serial_tx
  import i2s_serial_tx_pkg::*;
#(
  parameter int DATA_BITS = I2S_DATA_BITS,
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  parameter int BCK_HALF  = 2
) (
  input  logic                        AMCLK_i,
  input  logic                        reset_n,
  input  logic signed [DATA_BITS-1:0] APSDATA_LEFT_i,
  input  logic signed [DATA_BITS-1:0] APSDATA_RIGHT_i,
  input  logic                        APDATA_VALID_i,
  input  logic                        downsample_2x,
  output logic                        I2S_BCK,
  output logic                        I2S_WS,
  output logic                        I2S_DATA,
  output logic                        FRAME_START_o
);

  localparam int c_frame = 2 * SLOT_BITS;
  localparam int c_bw    = i2s_cnt_width(c_frame);
  localparam logic [c_bw-1:0] c_last_bit = c_bw'(c_frame - 1);
  localparam logic [c_bw-1:0] c_slot     = c_bw'(SLOT_BITS);
  localparam logic [c_bw-1:0] c_data     = c_bw'(DATA_BITS);

  logic                 w_bck;
  logic                 w_fall;
  logic [c_bw-1:0]      r_bitcnt;
  logic [c_bw-1:0]      w_bitcnt_nxt;
  logic [c_bw-1:0]      w_pos;
  logic                 w_right;
  logic                 w_load;
  logic                 w_shift;
  logic [DATA_BITS-1:0] r_hold_l;
  logic [DATA_BITS-1:0] r_hold_r;
  logic [DATA_BITS-1:0] r_sh_l;
  logic [DATA_BITS-1:0] r_sh_r;
  logic                 r_ws;
  logic                 r_data;
  logic                 r_fs;

  i2s_bck_prescaler #(
    .BCK_HALF (BCK_HALF)
  ) u_prescaler (
    .AMCLK_i         (AMCLK_i),
    .reset_n         (reset_n),
    .i_downsample_2x (downsample_2x),
    .o_bck           (w_bck),
    .o_fall_evt      (w_fall)
  );

  // Position decode uses the count that becomes current at this fall.
  always_comb begin
    w_bitcnt_nxt = (r_bitcnt == c_last_bit) ? '0 : r_bitcnt + 1'b1;
    w_right      = (w_bitcnt_nxt >= c_slot);
    w_pos        = w_right ? (w_bitcnt_nxt - c_slot) : w_bitcnt_nxt;
    w_load       = (w_bitcnt_nxt == '0);
    w_shift      = (w_pos != '0) && (w_pos <= c_data);
  end

  always_ff @(posedge AMCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      r_bitcnt <= c_last_bit;
      r_hold_l <= '0;
      r_hold_r <= '0;
      r_sh_l   <= '0;
      r_sh_r   <= '0;
      r_ws     <= 1'b0;
      r_data   <= 1'b0;
      r_fs     <= 1'b0;
    end else begin
      r_fs <= 1'b0;
      if (APDATA_VALID_i) begin
        r_hold_l <= APSDATA_LEFT_i;
        r_hold_r <= APSDATA_RIGHT_i;
      end
      if (w_fall) begin
        r_bitcnt <= w_bitcnt_nxt;
        r_ws     <= w_right;
        r_data   <= 1'b0;
        // Load sees the holding value from before any same-cycle capture.
        if (w_load) begin
          r_sh_l <= r_hold_l;
          r_sh_r <= r_hold_r;
          r_fs   <= 1'b1;
        end else if (w_shift) begin
          if (w_right) begin
            r_data <= r_sh_r[DATA_BITS-1];
            r_sh_r <= {r_sh_r[DATA_BITS-2:0], 1'b0};
          end else begin
            r_data <= r_sh_l[DATA_BITS-1];
            r_sh_l <= {r_sh_l[DATA_BITS-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign I2S_BCK       = w_bck;
  assign I2S_WS        = r_ws;
  assign I2S_DATA      = r_data;
  assign FRAME_START_o = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_i2s_serial_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_i2s_serial_tx
// Brief  : Self-checking bench for i2s_serial_tx (frame scoreboard + vectors).
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_i2s_serial_tx;
  import i2s_serial_tx_pkg::*;

  logic        AMCLK_i = 1'b0;
  logic        reset_n;
  logic [23:0] APSDATA_LEFT_i;
  logic [23:0] APSDATA_RIGHT_i;
  logic        APDATA_VALID_i;
  logic        downsample_2x;
  logic        I2S_BCK;
  logic        I2S_WS;
  logic        I2S_DATA;
  logic        FRAME_START_o;

  always #5 AMCLK_i = ~AMCLK_i;

  i2s_serial_tx #(
    .DATA_BITS (24),
    .SLOT_BITS (32),
    .BCK_HALF  (2)
  ) dut (
    .AMCLK_i         (AMCLK_i),
    .reset_n         (reset_n),
    .APSDATA_LEFT_i  (APSDATA_LEFT_i),
    .APSDATA_RIGHT_i (APSDATA_RIGHT_i),
    .APDATA_VALID_i  (APDATA_VALID_i),
    .downsample_2x   (downsample_2x),
    .I2S_BCK         (I2S_BCK),
    .I2S_WS          (I2S_WS),
    .I2S_DATA        (I2S_DATA),
    .FRAME_START_o   (FRAME_START_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference holding register: last captured sample, cleared by reset.
  stereo_sample_t m_hold;
  always @(posedge AMCLK_i or negedge reset_n) begin
    if (!reset_n)            m_hold <= '0;
    else if (APDATA_VALID_i) m_hold <= {APSDATA_LEFT_i, APSDATA_RIGHT_i};
  end

  // Frame monitor: samples on BCK rise, scoreboard holds per-frame expectations.
  stereo_sample_t exp_q[$];
  stereo_sample_t last_hold;
  stereo_sample_t e;
  logic        prev_bck;
  logic        collecting;
  logic        skip_phase;
  int          nbits;
  int          frames_done = 0;
  int          cyc = 0;
  int          last_fs_cyc = 0;
  int          fs_period = 0;
  int          cur_len = 0;
  int          last_phase = 0;
  int          min_phase = 1000;
  logic [31:0] cap_l, cap_r, last_cap_l, last_cap_r;
  logic [63:0] ws_bits;

  always @(negedge AMCLK_i) begin
    cyc++;
    if (!reset_n) begin
      collecting  = 1'b0;
      nbits       = 0;
      exp_q.delete();
      last_hold   = '0;
      prev_bck    = 1'b0;
      skip_phase  = 1'b1;
      cur_len     = 0;
      last_fs_cyc = cyc;
    end else begin
      if (I2S_BCK != prev_bck) begin
        if (skip_phase) skip_phase = 1'b0;
        else begin
          last_phase = cur_len;
          if (cur_len < min_phase) min_phase = cur_len;
        end
        cur_len = 1;
      end else begin
        cur_len++;
      end
      if (FRAME_START_o) begin
        if (collecting) check("frame_len", 64'(nbits), 64'd64);
        fs_period   = cyc - last_fs_cyc;
        last_fs_cyc = cyc;
        exp_q.push_back(last_hold);
        collecting = 1'b1;
        nbits      = 0;
        cap_l      = '0;
        cap_r      = '0;
        ws_bits    = '0;
      end else if (collecting && I2S_BCK && !prev_bck) begin
        if (nbits < 32) cap_l[31-nbits] = I2S_DATA;
        else            cap_r[63-nbits] = I2S_DATA;
        ws_bits[63-nbits] = I2S_WS;
        nbits++;
        if (nbits == 64) begin
          collecting = 1'b0;
          check("ws_pattern", ws_bits, 64'h0000_0000_FFFF_FFFF);
          if (exp_q.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
          end else begin
            e = exp_q.pop_front();
            check("sb_left",  64'(cap_l), 64'({1'b0, e.left,  7'b0}));
            check("sb_right", 64'(cap_r), 64'({1'b0, e.right, 7'b0}));
          end
          last_cap_l = cap_l;
          last_cap_r = cap_r;
          frames_done++;
        end
      end
      prev_bck  = I2S_BCK;
      last_hold = m_hold;
    end
  end

  task automatic drive_sample(input logic [23:0] l, input logic [23:0] r);
    APSDATA_LEFT_i  = l;
    APSDATA_RIGHT_i = r;
    APDATA_VALID_i  = 1'b1;
    @(negedge AMCLK_i);
    APDATA_VALID_i  = 1'b0;
  endtask

  task automatic wait_fs();
    int t = 0;
    do begin
      @(negedge AMCLK_i);
      t++;
    end while (!FRAME_START_o && t < 2000);
    if (!FRAME_START_o) check("fs_timeout", 64'd0, 64'd1);
    #1;
  endtask

  task automatic wait_frames(input int target);
    int t = 0;
    while (frames_done < target && t < 5000) begin
      @(negedge AMCLK_i);
      t++;
    end
    if (frames_done < target) check("frame_timeout", 64'(frames_done), 64'(target));
  endtask

  task automatic reset_release();
    logic [3:0] bseq;
    logic [3:0] fseq;
    @(negedge AMCLK_i);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge AMCLK_i);
      bseq[3-k] = I2S_BCK;
      fseq[3-k] = FRAME_START_o;
    end
    check("rel_bck_seq", 64'(bseq), 64'(4'b0110));
    check("rel_fs_seq",  64'(fseq), 64'(4'b0001));
    check("rel_ws",      64'(I2S_WS), 64'd0);
  endtask

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [31:0] el;
    logic [31:0] er;
  } vec_t;

  vec_t vecs[3];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int fd0;
    int t;
    vecs[0] = '{24'h800001, 24'h7FFFFF, 32'h4000_0080, 32'h3FFF_FF80};
    vecs[1] = '{24'hFFFFFF, 24'h000000, 32'h7FFF_FF80, 32'h0000_0000};
    vecs[2] = '{24'hA5A5A5, 24'h5A5A5A, 32'h52D2_D280, 32'h2D2D_2D00};

    reset_n         = 1'b0;
    downsample_2x   = 1'b0;
    APDATA_VALID_i  = 1'b0;
    APSDATA_LEFT_i  = '0;
    APSDATA_RIGHT_i = '0;

    // Reset held with toggling inputs
    for (int k = 0; k < 5; k++) begin
      @(negedge AMCLK_i);
      APDATA_VALID_i  = ~APDATA_VALID_i;
      APSDATA_LEFT_i  = 24'($urandom);
      APSDATA_RIGHT_i = 24'($urandom);
      check("reset_outputs", 64'({I2S_BCK, I2S_WS, I2S_DATA, FRAME_START_o}), 64'd0);
    end
    APDATA_VALID_i = 1'b0;
    reset_release();

    // Table-driven bit patterns, each sent in the frame after its valid
    for (int i = 0; i < 3; i++) begin
      if (i > 0) wait_fs();
      fd0 = frames_done;
      repeat (20) @(negedge AMCLK_i);
      drive_sample(vecs[i].l, vecs[i].r);
      wait_frames(fd0 + 2);
      check("vec_left",  64'(last_cap_l), 64'(vecs[i].el));
      check("vec_right", 64'(last_cap_r), 64'(vecs[i].er));
    end

    // Valid coinciding with the frame-load edge
    wait_fs();
    drive_sample(24'hABCDEF, 24'h0F1E2D);
    repeat (254) @(negedge AMCLK_i);
    APSDATA_LEFT_i  = 24'h123456;
    APSDATA_RIGHT_i = 24'h654321;
    APDATA_VALID_i  = 1'b1;
    @(negedge AMCLK_i);
    APDATA_VALID_i  = 1'b0;
    check("collision_align", 64'(FRAME_START_o), 64'd1);
    fd0 = frames_done;
    wait_frames(fd0 + 1);
    check("collision_old_l", 64'(last_cap_l), 64'h55E6_F780);
    check("collision_old_r", 64'(last_cap_r), 64'h078F_1680);
    wait_frames(fd0 + 2);
    check("collision_new_l", 64'(last_cap_l), 64'h091A_2B00);
    check("collision_new_r", 64'(last_cap_r), 64'h32A1_9080);

    // Starvation: sample repeats
    for (int k = 3; k <= 5; k++) begin
      wait_frames(fd0 + k);
      check("starve_l", 64'(last_cap_l), 64'h091A_2B00);
      check("starve_r", 64'(last_cap_r), 64'h32A1_9080);
    end

    // Two valids in one frame: only the later one is sent
    wait_fs();
    fd0 = frames_done;
    repeat (10) @(negedge AMCLK_i);
    drive_sample(24'h2468AC, 24'h13579B);
    repeat (20) @(negedge AMCLK_i);
    drive_sample(24'h13579B, 24'h7FFFFF);
    wait_frames(fd0 + 1);
    check("multi_prev_l", 64'(last_cap_l), 64'h091A_2B00);
    wait_frames(fd0 + 2);
    check("multi_l", 64'(last_cap_l), 64'h09AB_CD80);
    check("multi_r", 64'(last_cap_r), 64'h3FFF_FF80);

    // Rate switch mid-frame and back
    wait_fs();
    check("period_ds0", 64'(fs_period), 64'd256);
    repeat (37) @(negedge AMCLK_i);
    downsample_2x = 1'b1;
    wait_fs();
    wait_fs();
    check("period_ds1", 64'(fs_period), 64'd512);
    check("phase_ds1",  64'(last_phase), 64'd4);
    repeat (50) @(negedge AMCLK_i);
    downsample_2x = 1'b0;
    wait_fs();
    wait_fs();
    check("period_ds0_back", 64'(fs_period), 64'd256);
    check("phase_ds0",       64'(last_phase), 64'd2);
    check("min_phase",       64'(min_phase >= 2), 64'd1);

    // Reset asserted at bit 40 of a frame
    t = 0;
    while (!(collecting && nbits == 41) && t < 2000) begin
      @(negedge AMCLK_i);
      t++;
    end
    check("bit40_reached", 64'(nbits), 64'd41);
    #2;
    check("pre_reset_ws_data", 64'({I2S_WS, I2S_DATA}), 64'(2'b11));
    reset_n = 1'b0;
    #1;
    check("async_reset_out", 64'({I2S_BCK, I2S_WS, I2S_DATA, FRAME_START_o}), 64'd0);
    repeat (3) @(negedge AMCLK_i);
    reset_release();
    fd0 = frames_done;
    wait_frames(fd0 + 1);
    check("post_reset_l", 64'(last_cap_l), 64'd0);
    check("post_reset_r", 64'(last_cap_r), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
